if_de_stage: RTL and testbench
==============================

Name: if_de_stage

Overview:
- Parametrised successor of the IF/DE pipeline register. It generalises that register to any pipeline boundary of the core.
- Carries two kinds of payload:
  - Ordinary registered fields (PC, PC+4, decode tags).
  - Late-arriving data from a synchronous memory, such as the fetched instruction.
- Applies the shared WORK/STOP/REFRESH flow control to both.
- Adds a valid bit, selectable capture mode for the late data, and saturating stall and flush statistics counters read by the perf/debug CSRs.

Parameters:
- CTRL_W, 64: width of registered payload (ctrl_i/ctrl_o).
- SDATA_W, 32: width of late payload (sdata_i/sdata_o).
- SYNC_DATA, 1: 1 = sdata_i comes from a synchronous memory whose output is already delayed one cycle; 0 = sdata_i is registered like ctrl_i.
- CNT_W, 16: width of each statistics counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous assert, active-low
- flow_i  in  `FLOW_WIDTH  flow command for this boundary (`FLOW_WORK/`FLOW_STOP/`FLOW_REFRESH)
- valid_i  in  1  upstream slot holds a real instruction
- ctrl_i  in  CTRL_W  registered payload from upstream
- sdata_i  in  SDATA_W  late payload (memory read data or plain data)
- cnt_clr_i  in  1  synchronous clear of both counters
- valid_o  out  1  downstream slot valid
- ctrl_o  out  CTRL_W  registered payload to downstream
- sdata_o  out  SDATA_W  late payload to downstream
- stall_cnt_o  out  CNT_W  cycles spent in STOP
- flush_cnt_o  out  CNT_W  valid instructions killed by REFRESH

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset values:
  - valid_o=0, ctrl_o=0, sdata_o=0, counters=0.
  - Internal mode_q=`FLOW_REFRESH, hold_q=0.
- Registered path, updated on each posedge:
  - WORK: valid_q<=valid_i, ctrl_q<=ctrl_i.
  - STOP: hold both.
  - REFRESH or any unlisted code: valid_q<=0, ctrl_q<=0.
- Latency: one cycle from inputs to valid_o/ctrl_o.
- Late path, SYNC_DATA=1:
  - mode_q<=flow_i each cycle; unlisted codes map to REFRESH.
  - sdata_o is combinational from mode_q:
    - WORK: sdata_i.
    - STOP: hold_q.
    - REFRESH: 0.
  - hold_q<=sdata_o every cycle, so it always holds the last value presented downstream.
  - Consecutive STOPs keep returning the same word even though the memory output changes.
  - On STOP→WORK, sdata_o switches to the live sdata_i in the first WORK-mode cycle; nothing is replayed.
- Late path, SYNC_DATA=0: sdata_q behaves exactly like ctrl_q (WORK load, STOP hold, REFRESH zero), and sdata_o=sdata_q.
- WORK with valid_i=0 loads a bubble: valid_o=0, but ctrl_o/sdata_o still follow their inputs. Downstream must qualify with valid_o.
- stall_cnt:
  - +1 on each posedge where flow_i==STOP.
  - Saturates at all-ones.
- flush_cnt:
  - +1 on each posedge where flow_i is REFRESH (or unlisted) and valid_q==1.
  - REFRESH of an already-empty slot does not count.
  - Saturates at all-ones.
- cnt_clr_i=1 zeroes both counters on the next posedge. Clear wins over a simultaneous increment.
- Reset mid-stall: all state returns to reset values immediately (async). The first post-reset cycle behaves as REFRESH mode, so sdata_o=0.
- No combinational path from flow_i to any output. The only combinational input-to-output path is sdata_i→sdata_o in SYNC_DATA=1 WORK mode.

Decomposition:
- Existing shared defines header (rooth_defines.v) keeps `FLOW_WIDTH, `FLOW_WORK, `FLOW_STOP, `FLOW_REFRESH. Add `STAT_CNT_W default there.
- One natural sub-module: sat_counter (CNT_W; inc, clr, clr-priority, saturate). Instantiate it twice.
- All other logic lives in if_de_stage.

Test Plan:
- Reset: hold rst_n=0 with ctrl_i=0x1234, flow_i=WORK → all outputs 0. Release rst_n: first cycle sdata_o=0 even with sdata_i=0xDEADBEEF.
- WORK stream, SYNC_DATA=1: drive ctrl_i=0x100,0x104 with valid_i=1. Memory data 0xAAAA0001 arrives one cycle later → ctrl_o=0x100 aligned with sdata_o=0xAAAA0001, then 0x104 with the next word.
- Three-cycle STOP while memory output changes to 0x55555555 → ctrl_o and sdata_o hold their pre-stall values; stall_cnt_o=3.
- REFRESH on a valid slot, then REFRESH on the empty slot → valid_o=0, ctrl_o=0, sdata_o=0; flush_cnt_o=1, not 2.
- SYNC_DATA=0 instance with sequence WORK(0x11), STOP, WORK(0x22) → sdata_o=0x11 for 2 cycles, then 0x22.
- CNT_W=2: hold STOP for 5 cycles → stall_cnt_o=3 (saturated). Assert cnt_clr_i during a STOP cycle → stall_cnt_o=0 next cycle.

Source files
------------

// File: rtl/if_de_stage_pkg.sv
// if_de_stage_pkg: flow-control codes, statistics width and flow decoding shared by the pipeline boundary
package if_de_stage_pkg;
  localparam int FLOW_WIDTH = 2;
  localparam logic [FLOW_WIDTH-1:0] FLOW_WORK    = 2'd0;
  localparam logic [FLOW_WIDTH-1:0] FLOW_STOP    = 2'd1;
  localparam logic [FLOW_WIDTH-1:0] FLOW_REFRESH = 2'd2;
  localparam int STAT_CNT_W = 16;
  // unlisted codes are treated as REFRESH so a corrupt command flushes rather than leaks state
  function automatic logic [FLOW_WIDTH-1:0] flow_norm(input logic [FLOW_WIDTH-1:0] f);
    return (f == FLOW_WORK || f == FLOW_STOP) ? f : FLOW_REFRESH;
  endfunction
endpackage

// File: rtl/if_de_stage_sat_counter.sv
// if_de_stage_sat_counter: saturating up-counter with synchronous clear taking priority over increment
// Ports: clk, rst_n (async active-low), inc (count one), clr (zero next edge), cnt (current value)
module if_de_stage_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (inc && !(&cnt)) cnt <= cnt + 1'b1;
endmodule

// File: rtl/if_de_stage.sv
// if_de_stage: pipeline boundary register with WORK/STOP/REFRESH flow control, late-data capture and stall/flush statistics
// Ports: clk, rst_n (async active-low); flow_i boundary command; valid_i/ctrl_i registered payload;
//        sdata_i late payload; cnt_clr_i clears counters; valid_o/ctrl_o/sdata_o downstream payload;
//        stall_cnt_o cycles in STOP; flush_cnt_o valid slots killed by REFRESH
module if_de_stage
  import if_de_stage_pkg::*;
#(
  parameter int CTRL_W    = 64,
  parameter int SDATA_W   = 32,
  parameter int SYNC_DATA = 1,
  parameter int CNT_W     = STAT_CNT_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [FLOW_WIDTH-1:0] flow_i,
  input  logic                  valid_i,
  input  logic [CTRL_W-1:0]     ctrl_i,
  input  logic [SDATA_W-1:0]    sdata_i,
  input  logic                  cnt_clr_i,
  output logic                  valid_o,
  output logic [CTRL_W-1:0]     ctrl_o,
  output logic [SDATA_W-1:0]    sdata_o,
  output logic [CNT_W-1:0]      stall_cnt_o,
  output logic [CNT_W-1:0]      flush_cnt_o
);
  logic [FLOW_WIDTH-1:0] flow;
  logic                  valid_q;
  logic [CTRL_W-1:0]     ctrl_q;
  assign flow    = flow_norm(flow_i);
  assign valid_o = valid_q;
  assign ctrl_o  = ctrl_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
    end else if (flow == FLOW_WORK) begin
      valid_q <= valid_i;
      ctrl_q  <= ctrl_i;
    end else if (flow == FLOW_REFRESH) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
    end
  generate
    if (SYNC_DATA != 0) begin : g_sync
      logic [FLOW_WIDTH-1:0] mode_q;
      logic [SDATA_W-1:0]    hold_q;
      // the memory already delays its word by a cycle, so steer it with last cycle's command
      always_comb sdata_o = mode_q == FLOW_WORK ? sdata_i : mode_q == FLOW_STOP ? hold_q : '0;
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
          mode_q <= FLOW_REFRESH;
          hold_q <= '0;
        end else begin
          mode_q <= flow;
          hold_q <= sdata_o;
        end
    end else begin : g_reg
      logic [SDATA_W-1:0] sdata_q;
      assign sdata_o = sdata_q;
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) sdata_q <= '0;
        else if (flow == FLOW_WORK) sdata_q <= sdata_i;
        else if (flow == FLOW_REFRESH) sdata_q <= '0;
    end
  endgenerate
  if_de_stage_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (flow == FLOW_STOP),
    .clr  (cnt_clr_i),
    .cnt  (stall_cnt_o)
  );
  if_de_stage_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (flow == FLOW_REFRESH && valid_q),
    .clr  (cnt_clr_i),
    .cnt  (flush_cnt_o)
  );
endmodule

// File: tb/tb_if_de_stage.sv
// tb_if_de_stage: randomized and directed check of if_de_stage against a behavioural model
module tb_if_de_stage;
  import if_de_stage_pkg::*;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  flow = FLOW_WORK;
  logic        valid = 1'b0;
  logic        clr = 1'b0;
  logic [63:0] ctrl = '0;
  logic [31:0] sdata = '0;
  logic        va, vb, vc;
  logic [63:0] ca, cb, cc;
  logic [31:0] sa, sb, sc;
  logic [15:0] sta, fla, stb, flb;
  logic [1:0]  stc, flc;
  int n_chk = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  if_de_stage #(.SYNC_DATA(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .flow_i(flow), .valid_i(valid), .ctrl_i(ctrl), .sdata_i(sdata),
    .cnt_clr_i(clr), .valid_o(va), .ctrl_o(ca), .sdata_o(sa), .stall_cnt_o(sta), .flush_cnt_o(fla)
  );
  if_de_stage #(.SYNC_DATA(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .flow_i(flow), .valid_i(valid), .ctrl_i(ctrl), .sdata_i(sdata),
    .cnt_clr_i(clr), .valid_o(vb), .ctrl_o(cb), .sdata_o(sb), .stall_cnt_o(stb), .flush_cnt_o(flb)
  );
  if_de_stage #(.SYNC_DATA(1), .CNT_W(2)) dut_c (
    .clk(clk), .rst_n(rst_n), .flow_i(flow), .valid_i(valid), .ctrl_i(ctrl), .sdata_i(sdata),
    .cnt_clr_i(clr), .valid_o(vc), .ctrl_o(cc), .sdata_o(sc), .stall_cnt_o(stc), .flush_cnt_o(flc)
  );
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic logic [1:0] kind(input logic [1:0] f);
    return (f == FLOW_WORK || f == FLOW_STOP) ? f : FLOW_REFRESH;
  endfunction
  function automatic longint sat(input int n, input int w);
    return n > (1 << w) - 1 ? (1 << w) - 1 : n;
  endfunction
  logic        m_valid = 1'b0;
  logic [63:0] m_ctrl = '0;
  logic [1:0]  m_prev = FLOW_REFRESH;
  logic [31:0] m_shown = '0;
  logic [31:0] m_reg = '0;
  logic [31:0] exp_late;
  int n_stall = 0;
  int n_flush = 0;
  always_comb exp_late = m_prev == FLOW_WORK ? sdata : m_prev == FLOW_STOP ? m_shown : 32'h0;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_ctrl  <= '0;
      m_prev  <= FLOW_REFRESH;
      m_shown <= '0;
      m_reg   <= '0;
      n_stall <= 0;
      n_flush <= 0;
    end else begin
      m_prev  <= kind(flow);
      m_shown <= exp_late;
      n_stall <= clr ? 0 : n_stall + (kind(flow) == FLOW_STOP ? 1 : 0);
      n_flush <= clr ? 0 : n_flush + ((kind(flow) == FLOW_REFRESH && m_valid) ? 1 : 0);
      if (kind(flow) == FLOW_WORK) begin
        m_valid <= valid;
        m_ctrl  <= ctrl;
        m_reg   <= sdata;
      end else if (kind(flow) == FLOW_REFRESH) begin
        m_valid <= 1'b0;
        m_ctrl  <= '0;
        m_reg   <= '0;
      end
    end
  always @(negedge clk) begin
    chk("a_valid", va, m_valid);
    chk("a_ctrl", ca, m_ctrl);
    chk("a_sdata", sa, exp_late);
    chk("a_stall", sta, sat(n_stall, 16));
    chk("a_flush", fla, sat(n_flush, 16));
    chk("b_valid", vb, m_valid);
    chk("b_ctrl", cb, m_ctrl);
    chk("b_sdata", sb, m_reg);
    chk("b_stall", stb, sat(n_stall, 16));
    chk("b_flush", flb, sat(n_flush, 16));
    chk("c_valid", vc, m_valid);
    chk("c_sdata", sc, exp_late);
    chk("c_stall", stc, sat(n_stall, 2));
    chk("c_flush", flc, sat(n_flush, 2));
  end
  task automatic set(input logic [1:0] f, input logic v, input logic [63:0] c, input logic [31:0] s, input logic k);
    @(posedge clk);
    #1;
    flow = f; valid = v; ctrl = c; sdata = s; clr = k;
    #2;
  endtask
  initial begin
    set(FLOW_WORK, 1, 64'h1234, 32'hDEADBEEF, 0);
    set(FLOW_WORK, 1, 64'h1234, 32'hDEADBEEF, 0);
    chk("lit_rst_valid", va, 0);
    chk("lit_rst_ctrl", ca, 0);
    chk("lit_rst_sdata", sa, 0);
    chk("lit_rst_stall", sta, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #2;
    chk("lit_first_sdata", sa, 0);
    set(FLOW_WORK, 1, 64'h100, 32'h0, 0);
    set(FLOW_WORK, 1, 64'h104, 32'hAAAA0001, 0);
    chk("lit_work_ctrl0", ca, 64'h100);
    chk("lit_work_sdata0", sa, 32'hAAAA0001);
    chk("lit_work_valid0", va, 1);
    set(FLOW_STOP, 1, 64'h108, 32'hAAAA0002, 0);
    chk("lit_work_ctrl1", ca, 64'h104);
    chk("lit_work_sdata1", sa, 32'hAAAA0002);
    set(FLOW_STOP, 1, 64'h108, 32'h55555555, 0);
    set(FLOW_STOP, 1, 64'h108, 32'h55555555, 0);
    set(FLOW_WORK, 1, 64'h10C, 32'h55555555, 0);
    chk("lit_stop_ctrl", ca, 64'h104);
    chk("lit_stop_sdata", sa, 32'hAAAA0002);
    chk("lit_stop_cnt", sta, 3);
    set(FLOW_REFRESH, 0, 64'h110, 32'h12345678, 0);
    chk("lit_resume_sdata", sa, 32'h12345678);
    chk("lit_resume_ctrl", ca, 64'h10C);
    set(FLOW_REFRESH, 0, 64'h0, 32'h0, 0);
    set(FLOW_WORK, 0, 64'h0, 32'h0, 0);
    chk("lit_flush_valid", va, 0);
    chk("lit_flush_ctrl", ca, 0);
    chk("lit_flush_sdata", sa, 0);
    chk("lit_flush_cnt", fla, 1);
    set(FLOW_WORK, 1, 64'h0, 32'h11, 0);
    set(FLOW_STOP, 1, 64'h0, 32'h99, 0);
    chk("lit_reg_sdata0", sb, 32'h11);
    set(FLOW_WORK, 1, 64'h0, 32'h22, 0);
    chk("lit_reg_sdata1", sb, 32'h11);
    set(FLOW_WORK, 1, 64'h0, 32'h33, 0);
    chk("lit_reg_sdata2", sb, 32'h22);
    set(FLOW_WORK, 0, 64'h0, 32'h0, 1);
    for (int i = 0; i < 5; i++) set(FLOW_STOP, 0, 64'h0, 32'h0, 0);
    set(FLOW_STOP, 0, 64'h0, 32'h0, 1);
    chk("lit_sat_c", stc, 3);
    chk("lit_sat_a", sta, 5);
    set(FLOW_WORK, 0, 64'h0, 32'h0, 0);
    chk("lit_clr_c", stc, 0);
    chk("lit_clr_a", sta, 0);
    for (int i = 0; i < 3000; i++) begin
      int r;
      r = $urandom_range(0, 9);
      set(r < 5 ? FLOW_WORK : r < 8 ? FLOW_STOP : r == 8 ? FLOW_REFRESH : 2'd3,
          1'($urandom_range(0, 3) != 0), {$urandom, $urandom}, $urandom, 1'($urandom_range(0, 15) == 0));
      rst_n = 1'($urandom_range(0, 199) != 0);
    end
    rst_n = 1'b1;
    set(FLOW_WORK, 1, 64'h5, 32'h6, 0);
    set(FLOW_WORK, 1, 64'h7, 32'h8, 0);
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
